exe_stage_pipe: RTL
===================

Name: exe_stage_pipe

Overview:
Parametrised execute stage for the ARM-subset pipeline. It replaces the purely combinational execute stage with one that adds an integrated EXE/MEM pipeline register, an on-stage NZCV status register with S-bit update, freeze/flush control and a fixed branch-target calculation. It sits between the ID/EXE register and the memory stage, and feeds the branch target back to fetch.

Parameters:
DATA_W, 32, datapath width (ALU operands, PC, result); must be ≥ 16
REG_ADDR_W, 4, destination register index width
IMM_W, 24, signed branch immediate width
SHIFT_W, 12, shift-operand field width (fixed ARM layout; values other than 12 are unsupported)

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous active-high reset
freeze  in  1  hold EXE/MEM register and status register
flush  in  1  replace this cycle's capture with a bubble
valid_in  in  1  ID/EXE slot holds a real instruction
wb_en_in, mem_r_en_in, mem_w_en_in  in  1 each  control from decode
exe_cmd  in  4  ALU command
s_bit  in  1  update status flags
imm  in  1  shift operand is a rotated immediate
pc_in  in  DATA_W  PC+4 of the instruction
rn_val, rm_val  in  DATA_W  register operands
shift_operand  in  SHIFT_W  shifter field
signed_imm  in  IMM_W  branch offset
dest_in  in  REG_ADDR_W  destination register
sel_src1, sel_src2  in  2 each  forwarding selects (FORWARDING_EN only)
mem_fwd_val, wb_fwd_val  in  DATA_W each  forwarding data (FORWARDING_EN only)
status  out  4  registered NZCV, bits [3:0] = N,Z,C,V
branch_addr  out  DATA_W  combinational branch target
alu_res_out  out  DATA_W  registered ALU result
st_val_out  out  DATA_W  registered store data (final rm value)
dest_out  out  REG_ADDR_W  registered destination register
wb_en_out, mem_r_en_out, mem_w_en_out, valid_out  out  1 each  registered control

Behaviour:
- Reset (rst=1 at edge): every registered output and the status register become 0. Reset wins over flush and freeze. A reset arriving mid-stall discards the held instruction.
- Latency: one cycle from ID/EXE inputs to registered outputs. branch_addr is combinational, 0 cycles.
- Operand A = rn_val. Store data = rm_val, both after forwarding when enabled.
- val2 priority:
  - (mem_r_en_in | mem_w_en_in): zero-extended shift_operand[11:0].
  - else imm=1: zero-extended shift_operand[7:0], rotated right by 2*shift_operand[11:8].
  - else: rm_val shifted by shift_operand[11:7], type shift_operand[6:5]: 00 LSL, 01 LSR, 10 ASR, 11 ROR. Shift amount 0 returns rm_val unchanged.
- exe_cmd encoding:
  - 0001 MOV, 1001 MVN, 0010 ADD, 0011 ADC, 0100 SUB, 0101 SBC, 0110 AND, 0111 ORR, 1000 EOR.
  - Unlisted codes give result 0.
  - CMP uses SUB, TST uses AND, LDR/STR use ADD.
- Arithmetic is computed at DATA_W+1 bits.
  - C = carry out of the MSB. For SUB/SBC, C = NOT borrow.
  - SBC computes A − val2 − (NOT C), using the current registered C. ADC uses registered C.
  - V = signed overflow.
- Logical ops and MOV/MVN compute N and Z only; C and V hold their previous values.
- Status register updates at the edge only when s_bit & valid_in & ~flush & ~freeze & ~rst.
- branch_addr = pc_in + (sign_extend(signed_imm) << 2), wrapping modulo 2^DATA_W.
- Register capture priority: rst > flush > freeze > normal.
  - flush: valid_out, wb_en_out, mem_r_en_out, mem_w_en_out ← 0. Data outputs may take any value.
  - freeze: all registered outputs hold.
  - normal: capture. If valid_in=0, all enables are captured as 0.
- Simultaneous flush and freeze: flush wins; the bubble is inserted.

Optional Feature:
FORWARDING_EN.
- Defined: sel_srcX selects the operand source:
  - 00 = register value
  - 01 = mem_fwd_val
  - 10 = wb_fwd_val
  - 11 = register value
  - sel_src1 applies to rn_val; sel_src2 applies to rm_val, before val2 generation and store data.
- Undefined: the forwarding ports exist but are ignored; operands are always register values.

Decomposition:
- Package exe_pkg holds:
  - EXE_CMD localparams
  - shift-type codes
  - NZCV bit indices
  - the val2 mode enum (MEM_OFFSET, ROT_IMM, REG_SHIFT)
- One sub-module, exe_val2_gen, contains the val2 generator as pure combinational logic, so it can be unit-tested separately.
- ALU, status register and pipeline register stay inline.

Test Plan:
1. ADDS: rn=0x7FFFFFFF, rm=1, reg shift 0, s_bit=1 → next cycle alu_res_out=0x80000000, status NZCV=1001.
2. SUBS: rn=5, imm=1, shift_operand=0x005 → alu_res_out=0, status=0110 (Z=1, C=1 means no borrow).
3. MOV, register shift: rm_val=0x80000000, shift_operand ASR #4 (0x240) → alu_res_out=0xF8000000, status unchanged with s_bit=0.
4. Freeze and flush:
   - freeze=1 for 3 cycles with changing inputs → outputs and status constant.
   - flush=1 with freeze=1 → valid_out=0 and all enables 0 next cycle.
5. LDR: mem_r_en_in=1, rn=0x100, shift_operand=0xFFC → alu_res_out=0x10FC. Also pc_in=0x20, signed_imm=0xFFFFFE → branch_addr=0x18 combinationally.
6. Forwarding (FORWARDING_EN): sel_src1=01, mem_fwd_val=10, ADD with imm 3 → alu_res_out=13.
   - Reset check: rst mid-freeze → all outputs 0 next edge.

Source files
------------

// File: rtl/exe_pkg.sv
// Shared definitions for the execute stage.
// Holds the ALU command codes, shifter type codes, NZCV bit positions and
// the val2 operand-mode enum used by exe_stage_pipe and exe_val2_gen.
package exe_pkg;

  // ALU commands (CMP/TST/LDR/STR reuse SUB/AND/ADD)
  localparam logic [3:0] EXE_MOV = 4'b0001;
  localparam logic [3:0] EXE_MVN = 4'b1001;
  localparam logic [3:0] EXE_ADD = 4'b0010;
  localparam logic [3:0] EXE_ADC = 4'b0011;
  localparam logic [3:0] EXE_SUB = 4'b0100;
  localparam logic [3:0] EXE_SBC = 4'b0101;
  localparam logic [3:0] EXE_AND = 4'b0110;
  localparam logic [3:0] EXE_ORR = 4'b0111;
  localparam logic [3:0] EXE_EOR = 4'b1000;

  // shift_operand[6:5] shift types
  localparam logic [1:0] SH_LSL = 2'b00;
  localparam logic [1:0] SH_LSR = 2'b01;
  localparam logic [1:0] SH_ASR = 2'b10;
  localparam logic [1:0] SH_ROR = 2'b11;

  // NZCV positions in the status register
  localparam int N_BIT = 3;
  localparam int Z_BIT = 2;
  localparam int C_BIT = 1;
  localparam int V_BIT = 0;

  typedef enum logic [1:0] {
    MEM_OFFSET = 2'd0,
    ROT_IMM    = 2'd1,
    REG_SHIFT  = 2'd2
  } val2_mode_e;

endpackage

// File: rtl/exe_val2_gen.sv
// Second-operand (val2) generator, purely combinational.
// Ports:
//   mem_en        - instruction is a load/store: use 12-bit offset
//   imm           - rotated 8-bit immediate form
//   shift_operand - 12-bit ARM shifter field
//   rm_val        - register operand for the shifted-register form
//   val2          - generated operand
module exe_val2_gen
  import exe_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int SHIFT_W = 12
) (
  input  logic               mem_en,
  input  logic               imm,
  input  logic [SHIFT_W-1:0] shift_operand,
  input  logic [DATA_W-1:0]  rm_val,
  output logic [DATA_W-1:0]  val2
);

  // Rotate right; amounts wrap modulo DATA_W. An r of 0 makes the left
  // shift go by DATA_W, which yields 0, so the value passes unchanged.
  function automatic logic [DATA_W-1:0] ror(input logic [DATA_W-1:0] x,
                                            input int unsigned amt);
    int unsigned r;
    r = amt % DATA_W;
    return (x >> r) | (x << (DATA_W - r));
  endfunction

  val2_mode_e         mode;
  logic [4:0]         rot_amt;
  logic [4:0]         sh_amt;
  logic [DATA_W-1:0]  imm8;

  always_comb begin
    if (mem_en)   mode = MEM_OFFSET;
    else if (imm) mode = ROT_IMM;
    else          mode = REG_SHIFT;

    rot_amt = {shift_operand[11:8], 1'b0};
    sh_amt  = shift_operand[11:7];
    imm8    = DATA_W'(shift_operand[7:0]);
    val2    = '0;

    case (mode)
      MEM_OFFSET: val2 = DATA_W'(shift_operand[11:0]);
      ROT_IMM:    val2 = ror(imm8, int'(rot_amt));
      REG_SHIFT: begin
        case (shift_operand[6:5])
          SH_LSL:  val2 = rm_val << sh_amt;
          SH_LSR:  val2 = rm_val >> sh_amt;
          SH_ASR:  val2 = DATA_W'($signed(rm_val) >>> sh_amt);
          default: val2 = ror(rm_val, int'(sh_amt));
        endcase
      end
      default: val2 = '0;
    endcase
  end

endmodule

// File: rtl/exe_stage_pipe.sv
// Execute stage with integrated EXE/MEM register and NZCV status register.
// Ports:
//   clk/rst            - clock, synchronous active-high reset
//   freeze/flush       - hold the stage / capture a bubble (flush wins)
//   *_in, exe_cmd, ... - ID/EXE register contents
//   sel_src*, *_fwd_val- operand forwarding (only when FORWARDING_EN is defined)
//   status             - registered NZCV
//   branch_addr        - combinational pc_in + (sext(signed_imm) << 2)
//   *_out              - registered EXE/MEM outputs
// Build option: define FORWARDING_EN to enable the operand forwarding muxes.
module exe_stage_pipe
  import exe_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 4,
  parameter int IMM_W      = 24,
  parameter int SHIFT_W    = 12
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  freeze,
  input  logic                  flush,
  input  logic                  valid_in,
  input  logic                  wb_en_in,
  input  logic                  mem_r_en_in,
  input  logic                  mem_w_en_in,
  input  logic [3:0]            exe_cmd,
  input  logic                  s_bit,
  input  logic                  imm,
  input  logic [DATA_W-1:0]     pc_in,
  input  logic [DATA_W-1:0]     rn_val,
  input  logic [DATA_W-1:0]     rm_val,
  input  logic [SHIFT_W-1:0]    shift_operand,
  input  logic [IMM_W-1:0]      signed_imm,
  input  logic [REG_ADDR_W-1:0] dest_in,
  input  logic [1:0]            sel_src1,
  input  logic [1:0]            sel_src2,
  input  logic [DATA_W-1:0]     mem_fwd_val,
  input  logic [DATA_W-1:0]     wb_fwd_val,
  output logic [3:0]            status,
  output logic [DATA_W-1:0]     branch_addr,
  output logic [DATA_W-1:0]     alu_res_out,
  output logic [DATA_W-1:0]     st_val_out,
  output logic [REG_ADDR_W-1:0] dest_out,
  output logic                  wb_en_out,
  output logic                  mem_r_en_out,
  output logic                  mem_w_en_out,
  output logic                  valid_out
);

  localparam int M = DATA_W - 1;

  typedef struct packed {
    logic                  valid;
    logic                  wb_en;
    logic                  mem_r_en;
    logic                  mem_w_en;
    logic [DATA_W-1:0]     alu_res;
    logic [DATA_W-1:0]     st_val;
    logic [REG_ADDR_W-1:0] dest;
  } pipe_t;

  pipe_t             pipe_d, pipe_q;
  logic [3:0]        status_d, status_q;
  logic [DATA_W-1:0] op_a, op_m, val2, alu_res, b_eff;
  logic [DATA_W:0]   sum;
  logic              arith, c_new, v_new;
  logic [3:0]        flags_new;

  // ---------------- operand selection ----------------
`ifdef FORWARDING_EN
  always_comb begin
    case (sel_src1)
      2'b01:   op_a = mem_fwd_val;
      2'b10:   op_a = wb_fwd_val;
      default: op_a = rn_val;
    endcase
    case (sel_src2)
      2'b01:   op_m = mem_fwd_val;
      2'b10:   op_m = wb_fwd_val;
      default: op_m = rm_val;
    endcase
  end
`else
  assign op_a = rn_val;
  assign op_m = rm_val;
  logic unused_fwd;
  assign unused_fwd = ^{sel_src1, sel_src2, mem_fwd_val, wb_fwd_val};
`endif

  exe_val2_gen #(
    .DATA_W  (DATA_W),
    .SHIFT_W (SHIFT_W)
  ) u_val2 (
    .mem_en        (mem_r_en_in | mem_w_en_in),
    .imm           (imm),
    .shift_operand (shift_operand),
    .rm_val        (op_m),
    .val2          (val2)
  );

  // ---------------- ALU ----------------
  // Subtraction is a + ~b + carry_in, so carry out is already NOT borrow
  // and one overflow rule (on a and the effective b) covers add and sub.
  always_comb begin
    sum     = '0;
    alu_res = '0;
    b_eff   = val2;
    arith   = 1'b0;
    case (exe_cmd)
      EXE_MOV: alu_res = val2;
      EXE_MVN: alu_res = ~val2;
      EXE_AND: alu_res = op_a & val2;
      EXE_ORR: alu_res = op_a | val2;
      EXE_EOR: alu_res = op_a ^ val2;
      EXE_ADD: begin
        arith = 1'b1;
        sum   = {1'b0, op_a} + {1'b0, val2};
      end
      EXE_ADC: begin
        arith = 1'b1;
        sum   = {1'b0, op_a} + {1'b0, val2} + {{DATA_W{1'b0}}, status_q[C_BIT]};
      end
      EXE_SUB: begin
        arith = 1'b1;
        b_eff = ~val2;
        sum   = {1'b0, op_a} + {1'b0, ~val2} + {{DATA_W{1'b0}}, 1'b1};
      end
      EXE_SBC: begin
        arith = 1'b1;
        b_eff = ~val2;
        sum   = {1'b0, op_a} + {1'b0, ~val2} + {{DATA_W{1'b0}}, status_q[C_BIT]};
      end
      default: alu_res = '0;
    endcase
    if (arith) alu_res = sum[M:0];

    // logical ops leave C and V alone
    c_new = arith ? sum[DATA_W] : status_q[C_BIT];
    v_new = arith ? ((op_a[M] == b_eff[M]) && (alu_res[M] != op_a[M]))
                  : status_q[V_BIT];
    flags_new = {alu_res[M], (alu_res == '0), c_new, v_new};
  end

  // ---------------- branch target ----------------
  assign branch_addr = pc_in + (DATA_W'($signed(signed_imm)) << 2);

  // ---------------- EXE/MEM and status next state ----------------
  always_comb begin
    pipe_d   = pipe_q;
    status_d = status_q;
    if (flush) begin
      // bubble: only the control bits matter, data is left as held
      pipe_d.valid    = 1'b0;
      pipe_d.wb_en    = 1'b0;
      pipe_d.mem_r_en = 1'b0;
      pipe_d.mem_w_en = 1'b0;
    end else if (!freeze) begin
      pipe_d.valid    = valid_in;
      pipe_d.wb_en    = wb_en_in & valid_in;
      pipe_d.mem_r_en = mem_r_en_in & valid_in;
      pipe_d.mem_w_en = mem_w_en_in & valid_in;
      pipe_d.alu_res  = alu_res;
      pipe_d.st_val   = op_m;
      pipe_d.dest     = dest_in;
      if (s_bit && valid_in) status_d = flags_new;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pipe_q   <= '0;
      status_q <= '0;
    end else begin
      pipe_q   <= pipe_d;
      status_q <= status_d;
    end
  end

  assign status       = status_q;
  assign alu_res_out  = pipe_q.alu_res;
  assign st_val_out   = pipe_q.st_val;
  assign dest_out     = pipe_q.dest;
  assign wb_en_out    = pipe_q.wb_en;
  assign mem_r_en_out = pipe_q.mem_r_en;
  assign mem_w_en_out = pipe_q.mem_w_en;
  assign valid_out    = pipe_q.valid;

endmodule
